// File: rtl/sigma_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sigma_pkg                                                   |
// | Purpose : Shared constants and types for the matrix serializer:       |
// |           IEEE-754 double field widths and the streaming FSM state.   |
// | Ports   : none (package)                                              |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package sigma_pkg;

  localparam int FP_WIDTH   = 64;
  localparam int EXP_WIDTH  = 11;
  localparam int FRAC_WIDTH = 52;

  // Explicitly encoded 2-bit state space of the serializer FSM.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage : sigma_pkg
`default_nettype wire

// File: rtl/fp64_ftz.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fp64_ftz                                                    |
// | Purpose : Combinational flush-to-zero for IEEE-754 doubles. A         |
// |           subnormal (exponent 0, fraction nonzero) becomes a signed   |
// |           zero; every other encoding passes through unchanged.        |
// | Ports   : i_data [63:0]  value in                                     |
// |           o_data [63:0]  flushed value out                            |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module fp64_ftz
  import sigma_pkg::*;
(
  input  logic [FP_WIDTH-1:0] i_data,
  output logic [FP_WIDTH-1:0] o_data
);

  logic w_exp_zero;
  logic w_frac_nonzero;

  always_comb begin
    w_exp_zero     = (i_data[FP_WIDTH-2 -: EXP_WIDTH] == '0);
    w_frac_nonzero = (i_data[FRAC_WIDTH-1:0] != '0);
    o_data         = i_data;
    if (w_exp_zero && w_frac_nonzero) begin
      // Keep the sign so -subnormal flushes to -0.0.
      o_data = {i_data[FP_WIDTH-1], {(FP_WIDTH-1){1'b0}}};
    end
  end

endmodule : fp64_ftz
`default_nettype wire

// File: rtl/matrix_serialize.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : matrix_serialize                                            |
// | Purpose : Captures a SIZE x SIZE matrix of doubles on load and        |
// |           streams its elements out row-major over a valid/ready       |
// |           handshake, then pulses done for one cycle.                  |
// | Config  : SIGMA_FTZ_EN - when defined, subnormal elements are output  |
// |           as signed zero through fp64_ftz.                            |
// | Ports   : clk         clock (rising edge)                             |
// |           rst         synchronous reset, active low                   |
// |           mat         packed matrix, (i,j) at [64*(i*SIZE+j) +: 64]   |
// |           load        capture request (honoured in IDLE/DONE only)    |
// |           busy        streaming in progress                           |
// |           elem        current element                                 |
// |           elem_valid  elem is valid                                   |
// |           elem_ready  downstream accepts elem                         |
// |           elem_row    row index of elem                               |
// |           elem_col    column index of elem                            |
// |           last        elem is element (SIZE-1, SIZE-1)                |
// |           done        one-cycle pulse after the final transfer        |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module matrix_serialize
  import sigma_pkg::*;
#(
  parameter int SIZE = 2,
  localparam int IW  = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SIZE*SIZE*FP_WIDTH-1:0] mat,
  input  logic                         load,
  output logic                         busy,
  output logic [FP_WIDTH-1:0]          elem,
  output logic                         elem_valid,
  input  logic                         elem_ready,
  output logic [IW-1:0]                elem_row,
  output logic [IW-1:0]                elem_col,
  output logic                         last,
  output logic                         done
);

  localparam int NE  = SIZE * SIZE;
  localparam int NIW = (NE > 1) ? $clog2(NE) : 1;
  localparam logic [IW-1:0] C_MAX_IDX = IW'(SIZE - 1);

  state_t                   r_state;
  state_t                   w_next_state;
  logic [NE*FP_WIDTH-1:0]   r_mat;
  logic [IW-1:0]            r_row;
  logic [IW-1:0]            r_col;
  // Flat element index kept alongside row/col so the element select
  // needs no multiplier.
  logic [NIW-1:0]           r_idx;

  logic                     w_streaming;
  logic                     w_can_load;
  logic                     w_xfer;
  logic                     w_at_last;
  logic [FP_WIDTH-1:0]      w_raw;
  logic [FP_WIDTH-1:0]      w_elem;

  assign w_streaming = (r_state == ST_STREAM);
  assign w_can_load  = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_xfer      = w_streaming && elem_ready;
  assign w_at_last   = (r_row == C_MAX_IDX) && (r_col == C_MAX_IDX);

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (load) w_next_state = ST_STREAM;
      end
      ST_STREAM: begin
        if (w_xfer && w_at_last) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        w_next_state = load ? ST_STREAM : ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Capture register and index counters
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mat <= '0;
      r_row <= '0;
      r_col <= '0;
      r_idx <= '0;
    end else if (w_can_load && load) begin
      r_mat <= mat;
      r_row <= '0;
      r_col <= '0;
      r_idx <= '0;
    end else if (w_xfer) begin
      if (w_at_last) begin
        // Park at (0,0) so indices read zero while idle.
        r_row <= '0;
        r_col <= '0;
        r_idx <= '0;
      end else begin
        r_idx <= r_idx + 1'b1;
        if (r_col == C_MAX_IDX) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  // Element select from the captured copy, never from the live input.
  always_comb begin
    w_raw = r_mat[FP_WIDTH*int'(r_idx) +: FP_WIDTH];
  end

`ifdef SIGMA_FTZ_EN
  fp64_ftz u_ftz (
    .i_data (w_raw),
    .o_data (w_elem)
  );
`else
  assign w_elem = w_raw;
`endif

  // ------------------------------------------------------------------
  // FSM: output logic
  // ------------------------------------------------------------------
  always_comb begin
    busy       = w_streaming;
    elem_valid = w_streaming;
    done       = (r_state == ST_DONE);
    last       = w_streaming && w_at_last;
    elem       = w_streaming ? w_elem : '0;
    elem_row   = r_row;
    elem_col   = r_col;
  end

endmodule : matrix_serialize
`default_nettype wire

// File: tb/tb_matrix_serialize.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_matrix_serialize                                         |
// | Purpose : Self-checking bench for matrix_serialize with SIZE=3        |
// |           (random matrices, ready patterns, mid-stream load, abort),  |
// |           SIZE=2 (reference vector) and SIZE=1 (single element).      |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_matrix_serialize;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  // SIZE=3 instance
  logic [9*64-1:0] mat3;
  logic            load3, ready3;
  logic            busy3, valid3, last3, done3;
  logic [63:0]     elem3;
  logic [1:0]      row3, col3;

  // SIZE=2 instance
  logic [4*64-1:0] mat2;
  logic            load2, ready2;
  logic            busy2, valid2, last2, done2;
  logic [63:0]     elem2;
  logic [0:0]      row2, col2;

  // SIZE=1 instance
  logic [63:0]     mat1;
  logic            load1, ready1;
  logic            busy1, valid1, last1, done1;
  logic [63:0]     elem1;
  logic [0:0]      row1, col1;

  matrix_serialize #(.SIZE(3)) u_dut3 (
    .clk(clk), .rst(rst), .mat(mat3), .load(load3), .busy(busy3),
    .elem(elem3), .elem_valid(valid3), .elem_ready(ready3),
    .elem_row(row3), .elem_col(col3), .last(last3), .done(done3)
  );

  matrix_serialize #(.SIZE(2)) u_dut2 (
    .clk(clk), .rst(rst), .mat(mat2), .load(load2), .busy(busy2),
    .elem(elem2), .elem_valid(valid2), .elem_ready(ready2),
    .elem_row(row2), .elem_col(col2), .last(last2), .done(done2)
  );

  matrix_serialize #(.SIZE(1)) u_dut1 (
    .clk(clk), .rst(rst), .mat(mat1), .load(load1), .busy(busy1),
    .elem(elem1), .elem_valid(valid1), .elem_ready(ready1),
    .elem_row(row1), .elem_col(col1), .last(last1), .done(done1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference value of an element as seen on the output.
  function automatic logic [63:0] model(input logic [63:0] v);
`ifdef SIGMA_FTZ_EN
    if (v[62:52] == 11'd0 && v[51:0] != 52'd0) return {v[63], 63'd0};
`endif
    return v;
  endfunction

  // Random double with a bias toward subnormals and zeros.
  function automatic logic [63:0] rand_elem();
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom % 4)
      0: v[62:52] = '0;
      1: begin v[62:52] = '0; v[51:0] = '0; end
      default: ;
    endcase
    return v;
  endfunction

  task automatic check_idle3(input string tag);
    check({tag, "_busy"},  busy3,  0);
    check({tag, "_valid"}, valid3, 0);
    check({tag, "_done"},  done3,  0);
    check({tag, "_last"},  last3,  0);
    check({tag, "_elem"},  elem3,  0);
    check({tag, "_row"},   row3,   0);
    check({tag, "_col"},   col3,   0);
  endtask

  // ready_mode: 0 always ready, 1 pattern 1,0,0 repeating, 2 random.
  // abort_after >= 0 drops rst after that many transfers.
  task automatic run3(input int ready_mode, input bit poke_load, input int abort_after);
    logic [9*64-1:0] m;
    logic [63:0]     expq [9];
    int              k, cyc;
    bit              r;
    for (int i = 0; i < 9; i++) m[64*i +: 64] = rand_elem();
    for (int row = 0; row < 3; row++)
      for (int col = 0; col < 3; col++)
        expq[row*3+col] = model(m[64*(row*3+col) +: 64]);

    @(negedge clk);
    mat3 = m; load3 = 1'b1; ready3 = 1'b0;
    @(negedge clk);
    load3 = 1'b0;
    k = 0; cyc = 0;
    while (k < 9 && cyc < 100) begin
      check("s3_valid", valid3, 1);
      check("s3_busy",  busy3,  1);
      check("s3_done",  done3,  0);
      check("s3_elem",  elem3,  expq[k]);
      check("s3_row",   row3,   64'(k / 3));
      check("s3_col",   col3,   64'(k % 3));
      check("s3_last",  last3,  (k == 8) ? 1 : 0);
      if (abort_after >= 0 && k == abort_after) begin
        rst = 1'b0; ready3 = 1'b0;
        @(negedge clk);
        check_idle3("abort");
        rst = 1'b1;
        @(negedge clk);
        check_idle3("post_abort");
        return;
      end
      case (ready_mode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = $urandom_range(0, 1) != 0;
      endcase
      ready3 = r;
      // Live input churns and load may pulse; neither should matter now.
      for (int i = 0; i < 18; i++) mat3[32*i +: 32] = $urandom;
      load3 = (poke_load && (cyc == 2 || cyc == 5));
      @(negedge clk);
      if (r) k++;
      cyc++;
    end
    ready3 = 1'b0; load3 = 1'b0;
    check("s3_xfer_count", k, 9);
    check("s3_done_pulse", done3,  1);
    check("s3_done_busy",  busy3,  0);
    check("s3_done_valid", valid3, 0);
    @(negedge clk);
    check("s3_done_end", done3, 0);
    check("s3_idle_busy", busy3, 0);
  endtask

  logic [63:0] exp2 [4];

  initial begin
    rst = 1'b0;
    mat3 = '0; load3 = 1'b0; ready3 = 1'b0;
    mat2 = '0; load2 = 1'b0; ready2 = 1'b0;
    mat1 = '0; load1 = 1'b0; ready1 = 1'b0;

    // Reset with load held: load must be ignored.
    @(negedge clk);
    load3 = 1'b1; mat3 = {18{32'hDEADBEEF}};
    @(negedge clk);
    check_idle3("reset");
    rst = 1'b1; load3 = 1'b0;
    @(negedge clk);
    check_idle3("reset_load_ignored");

    // SIZE=2 reference vector.
    exp2[0] = 64'h3FF0000000000000;
    exp2[1] = 64'hC08B900000000000;
`ifdef SIGMA_FTZ_EN
    exp2[2] = 64'h0000000000000000;
`else
    exp2[2] = 64'h000012688B70E62B;
`endif
    exp2[3] = 64'hC053133333333334;
    mat2 = {64'hC053133333333334, 64'h000012688B70E62B,
            64'hC08B900000000000, 64'h3FF0000000000000};
    ready2 = 1'b1; load2 = 1'b1;
    @(negedge clk);
    load2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("s2_valid", valid2, 1);
      check("s2_elem",  elem2,  exp2[k]);
      check("s2_row",   row2,   64'(k / 2));
      check("s2_col",   col2,   64'(k % 2));
      check("s2_last",  last2,  (k == 3) ? 1 : 0);
      @(negedge clk);
    end
    check("s2_done",  done2,  1);
    check("s2_valid_done", valid2, 0);
    ready2 = 1'b0;
    @(negedge clk);
    check("s2_done_end", done2, 0);

    // SIZE=1 single element.
    mat1 = 64'h8000000000000001;
    ready1 = 1'b0; load1 = 1'b1;
    @(negedge clk);
    load1 = 1'b0;
    check("s1_valid", valid1, 1);
    check("s1_last",  last1,  1);
`ifdef SIGMA_FTZ_EN
    check("s1_elem",  elem1,  64'h8000000000000000);
`else
    check("s1_elem",  elem1,  64'h8000000000000001);
`endif
    @(negedge clk);
    check("s1_hold", valid1, 1);
    ready1 = 1'b1;
    @(negedge clk);
    ready1 = 1'b0;
    check("s1_done", done1, 1);
    check("s1_valid_done", valid1, 0);
    @(negedge clk);
    check("s1_done_end", done1, 0);

    // SIZE=3 streams.
    run3(0, 1'b0, -1);
    run3(1, 1'b0, -1);
    run3(2, 1'b1, -1);
    run3(1, 1'b1, -1);
    run3(0, 1'b0, 2);
    run3(0, 1'b0, -1);
    for (int n = 0; n < 4; n++) run3(2, 1'b1, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_matrix_serialize
`default_nettype wire

// File: doc/matrix_serialize.md
MATRIX_SERIALIZE -- requirements
Module: matrix_serialize

Interface
REQ-001 SHALL have parameter SIZE, default 2, giving matrix dimension (SIZE x SIZE elements, SIZE >= 1).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port mat  input  SIZE*SIZE*64  packed IEEE-754 double matrix; element (i,j) (0-based row i, column j) at bits [64*(i*SIZE+j) +: 64].
REQ-005 SHALL have port load  input  1  request to capture mat.
REQ-006 SHALL have port busy  output  1  high while a captured matrix is being streamed.
REQ-007 SHALL have port elem  output  64  current element.
REQ-008 SHALL have port elem_valid  output  1  elem is valid.
REQ-009 SHALL have port elem_ready  input  1  downstream accepts elem.
REQ-010 SHALL have ports elem_row and elem_col  output  IW each (IW = max(1, clog2(SIZE)))  indices of elem.
REQ-011 SHALL have port last  output  1  high with elem_valid on element (SIZE-1, SIZE-1).
REQ-012 SHALL have port done  output  1  one-cycle pulse after final transfer.

Function
REQ-013 SHALL implement FSM IDLE, STREAM, DONE.
REQ-014 IDLE/DONE: load=1 at an edge captures mat into an internal register, resets indices to (0,0), enters STREAM; elem_valid high from the next cycle (1-cycle latency).
REQ-015 STREAM: elem_valid=1, busy=1; elem/elem_row/elem_col/last reflect current index from captured register, never the live mat input.
REQ-016 A transfer SHALL occur exactly when elem_valid && elem_ready at an edge; index advances row-major (col increments, wraps to 0 with row increment at col=SIZE-1).
REQ-017 Without transfer, elem and indices SHALL hold stable (no change while elem_ready=0).
REQ-018 Transfer with last=1 SHALL enter DONE; DONE lasts one cycle with done=1, busy=0, elem_valid=0, then IDLE unless load=1.
REQ-019 load SHALL be ignored while in STREAM; mat changes during STREAM SHALL not affect output.
REQ-020 SIZE=1: single element, last=1 on first valid cycle.
REQ-021 Exactly SIZE*SIZE transfers SHALL occur per load.

Reset
REQ-022 rst=0 at an edge SHALL force IDLE, busy=0, elem_valid=0, done=0, last=0, elem=0, elem_row=0, elem_col=0, captured register=0, including mid-stream (stream aborted, no done pulse).
REQ-023 load asserted while rst=0 SHALL be ignored.

Configuration
REQ-024 Macro SIGMA_FTZ_EN defined: any element with exponent field 0 and nonzero fraction (subnormal) SHALL be output as signed zero (sign preserved, bits 62:0 zero); other values unchanged.
REQ-025 Macro undefined: elements SHALL be output bit-exact, no flush logic present.

Structure
REQ-026 Shared package sigma_pkg SHALL hold FP_WIDTH=64, exponent/fraction field widths, and the FSM state typedef.
REQ-027 Flush logic SHALL be a sub-module fp64_ftz (combinational, 64-bit in/out), instantiated only under SIGMA_FTZ_EN.

Verification
REQ-028 SIZE=2, mat={C053133333333334, 000012688B70E62B, C08B900000000000, 3FF0000000000000} (MSW first), elem_ready=1, no FTZ -> elem sequence 3FF0000000000000, C08B900000000000, 000012688B70E62B, C053133333333334 on 4 consecutive cycles, indices (0,0),(0,1),(1,0),(1,1), last on 4th, done pulse next cycle.
REQ-029 Same stimulus with SIGMA_FTZ_EN -> third element 0000000000000000, others unchanged.
REQ-030 SIZE=3, elem_ready toggled 1,0,0,1,... -> 9 transfers exactly, elem/indices stable during every ready=0 cycle, order row-major.
REQ-031 load pulsed mid-stream with different mat -> ignored, original 9 elements delivered.
REQ-032 rst=0 after 2 transfers -> next cycle busy=0, elem_valid=0, no done; new load restarts at (0,0).
REQ-033 SIZE=1, mat=8000000000000001, with SIGMA_FTZ_EN -> one element 8000000000000000 with last=1, then done.
